// File: rtl/sha_state_sequencer_pkg.sv
// ============================================================================
// sha_state_sequencer_pkg: shared constants and state encoding for the
// SHA-256 state-bank sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sha_state_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_READ   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // Ascending range so SHA256_IV[0] is H0 and sits in the top 32 bits.
  localparam logic [0:7][31:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Logical word -> bank address; the bank's memory map is not in word order.
  localparam logic [7:0][2:0] ADDR_MAP = {
    3'd5, 3'd3, 3'd2, 3'd1, 3'd0, 3'd6, 3'd4, 3'd7
  };

endpackage : sha_state_sequencer_pkg

`default_nettype wire

// File: rtl/sha_state_sequencer.sv
// ============================================================================
// sha_state_sequencer: loads the IV into the SHA state bank, runs num_blocks
// compression rounds and reads the 8 state words back into a digest.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sha_state_sequencer
  import sha_state_sequencer_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 NBLK_W     = 16,
  parameter logic [DATA_W-1:0]  DELAY_VAL  = '0,
  parameter int                 DONE_GUARD = 2,
  parameter int                 TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NBLK_W-1:0]     num_blocks,
  input  logic                  iv_sel,
  input  logic [8*DATA_W-1:0]   iv_in,
  output logic                  busy,
  output logic                  finished,
  output logic                  error,
  output logic [8*DATA_W-1:0]   digest,
  output logic                  st_valid,
  output logic [2:0]            st_addr,
  output logic [3:0]            st_wstrb,
  output logic [DATA_W-1:0]     st_wdata,
  input  logic                  st_ready,
  input  logic [DATA_W-1:0]     st_rdata,
  output logic                  st_run,
  input  logic                  st_done,
  output logic [DATA_W-1:0]     st_delay
);

  localparam int                WCNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] GUARD_CNT   = WCNT_W'(DONE_GUARD);
  localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(TIMEOUT);

  state_t                   state;
  state_t                   state_nxt;
  logic [2:0]               widx;
  logic [NBLK_W-1:0]        blk_left;
  logic [WCNT_W-1:0]        wait_cnt;
  logic [0:7][DATA_W-1:0]   iv_q;
  logic [0:7][DATA_W-1:0]   digest_q;
  logic                     err_q;
  logic                     done_ok;
  logic                     timed_out;

  // st_done is only trusted once the guard window after st_run has elapsed.
  assign done_ok   = (wait_cnt >= GUARD_CNT) && st_done;
  assign timed_out = (wait_cnt == TIMEOUT_CNT);

  assign error    = err_q;
  assign digest   = digest_q;
  assign st_delay = DELAY_VAL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    finished  = 1'b0;
    st_valid  = 1'b0;
    st_addr   = 3'd0;
    st_wstrb  = 4'h0;
    st_wdata  = '0;
    st_run    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        st_valid = 1'b1;
        st_addr  = ADDR_MAP[widx];
        st_wstrb = 4'hF;
        st_wdata = iv_q[widx];
        if (st_ready && (widx == 3'd7)) begin
          state_nxt = (blk_left != '0) ? ST_RUN : ST_READ;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        st_run    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (done_ok) begin
          state_nxt = (blk_left != NBLK_W'(1)) ? ST_RUN : ST_READ;
        end else if (timed_out) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_READ: begin
        busy     = 1'b1;
        st_valid = 1'b1;
        st_addr  = ADDR_MAP[widx];
        if (st_ready && (widx == 3'd7)) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        finished  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx     <= 3'd0;
      blk_left <= '0;
      wait_cnt <= '0;
      iv_q     <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            blk_left <= num_blocks;
            iv_q     <= iv_sel ? iv_in : SHA256_IV;
            err_q    <= 1'b0;
            widx     <= 3'd0;
          end
        end
        ST_LOAD: begin
          if (st_ready) widx <= widx + 3'd1;
        end
        ST_RUN: begin
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (done_ok) begin
            blk_left <= blk_left - NBLK_W'(1);
          end else if (timed_out) begin
            err_q <= 1'b1;
          end
          if (!timed_out) wait_cnt <= wait_cnt + WCNT_W'(1);
        end
        ST_READ: begin
          if (st_ready) begin
            digest_q[widx] <= st_rdata;
            widx           <= widx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : sha_state_sequencer

`default_nettype wire

// File: tb/tb_sha_state_sequencer.sv
// ============================================================================
// tb_sha_state_sequencer: table-driven self-checking bench with a small
// behavioural model of the SHA state bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sha_state_sequencer;

  localparam logic [31:0] DELAY_VAL = 32'h0000_00A5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  num_blocks = '0;
  logic         iv_sel = 1'b0;
  logic [255:0] iv_in = '0;
  logic         busy, finished, error;
  logic [255:0] digest;
  logic         st_valid;
  logic [2:0]   st_addr;
  logic [3:0]   st_wstrb;
  logic [31:0]  st_wdata;
  logic         st_ready = 1'b0;
  logic [31:0]  st_rdata = '0;
  logic         st_run;
  logic         st_done = 1'b0;
  logic [31:0]  st_delay;

  sha_state_sequencer #(
    .DATA_W(32), .NBLK_W(16), .DELAY_VAL(DELAY_VAL), .DONE_GUARD(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .iv_sel(iv_sel), .iv_in(iv_in), .busy(busy), .finished(finished),
    .error(error), .digest(digest), .st_valid(st_valid), .st_addr(st_addr),
    .st_wstrb(st_wstrb), .st_wdata(st_wdata), .st_ready(st_ready),
    .st_rdata(st_rdata), .st_run(st_run), .st_done(st_done), .st_delay(st_delay)
  );

  always #5 clk = ~clk;

  // Reference constants, written out independently of the design package.
  logic [255:0] std_iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [255:0] iv_a   = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
  logic [255:0] iv_b   = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  int map_t [8] = '{7, 4, 6, 0, 1, 2, 3, 5};

  int checks = 0;
  int errors = 0;

  // Bank model controls (bench-written) and observations (monitor-written).
  int ready_mode = 0;   // 0: always ready, 1: random stalls
  int done_lat   = 3;   // cycles from st_run to st_done; 0 = never
  logic [31:0] bank [8];
  int done_cnt = 0;
  int wr_cnt = 0, rd_cnt = 0, run_cnt = 0, hold_viol = 0, valid_cyc = 0, fin_cnt = 0;
  logic [2:0]  wr_addr_log [512];
  logic [31:0] wr_data_log [512];
  logic        prev_stall = 1'b0;
  logic [2:0]  p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  // Bank responds on the falling edge; its outputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      st_ready   = 1'b0;
      st_done    = 1'b0;
      st_rdata   = '0;
      done_cnt   = 0;
      prev_stall = 1'b0;
      for (int a = 0; a < 8; a++) bank[a] = 32'h0BAD_0000 + 32'(a);
    end else begin
      if (prev_stall && (!st_valid || st_addr != p_addr || st_wdata != p_wdata || st_wstrb != p_wstrb))
        hold_viol++;
      if (st_valid) valid_cyc++;
      if (finished) fin_cnt++;
      if (st_run) begin
        run_cnt++;
        for (int a = 0; a < 8; a++) bank[a] = bank[a] + 32'(a + 1);
        st_done  = 1'b0;
        done_cnt = done_lat;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) st_done = 1'b1;
      end
      st_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      st_rdata = 32'hDEAD_BEEF;
      if (st_valid && st_ready) begin
        if (st_wstrb == 4'hF) begin
          wr_addr_log[wr_cnt % 512] = st_addr;
          wr_data_log[wr_cnt % 512] = st_wdata;
          bank[st_addr] = st_wdata;
          wr_cnt++;
        end else begin
          st_rdata = bank[st_addr];
          rd_cnt++;
        end
      end
      prev_stall = st_valid && !st_ready;
      p_addr  = st_addr;
      p_wdata = st_wdata;
      p_wstrb = st_wstrb;
    end
  end

  typedef struct {
    logic [15:0]  nblk;
    logic         sel;
    logic [255:0] iv;
    int           rmode;
    int           dlat;
    int           poke_busy;   // cycle index at which a stray start is pulsed; 0 = none
    bit           poke_fin;    // pulse start in the FINISH cycle
    int           exp_lat;     // 0 = latency not checked (random stalls)
    int           exp_runs;
    int           exp_rd;
    logic         exp_err;
    logic [255:0] exp_dig;
  } vec_t;

  vec_t vecs [7];
  logic [255:0] last_dig = '0;

  function automatic logic [255:0] mk_dig(input logic [255:0] iv, input int nblk);
    logic [255:0] r;
    for (int w = 0; w < 8; w++)
      r[255-32*w -: 32] = iv[255-32*w -: 32] + 32'(nblk * (map_t[w] + 1));
    return r;
  endfunction

  function automatic vec_t mkv(input int nblk, input bit sel, input logic [255:0] iv,
                               input int rmode, input int dlat, input int pb, input bit pf,
                               input int lat, input bit err, input logic [255:0] dig);
    vec_t v;
    v.nblk = 16'(nblk); v.sel = sel; v.iv = iv; v.rmode = rmode; v.dlat = dlat;
    v.poke_busy = pb; v.poke_fin = pf; v.exp_lat = lat; v.exp_runs = nblk;
    v.exp_rd = err ? 0 : 8; v.exp_err = err; v.exp_dig = dig;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat, wb, rb, runb, hb, fb, vb;
    bit got, ok;
    logic [255:0] ivx;
    wb = wr_cnt; rb = rd_cnt; runb = run_cnt; hb = hold_viol; fb = fin_cnt;
    ready_mode = v.rmode;
    done_lat   = v.dlat;
    @(negedge clk);
    num_blocks = v.nblk; iv_sel = v.sel; iv_in = v.iv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk("busy_start", busy, 1'b1);
    chk("error_cleared", error, 1'b0);
    chk("digest_hold", digest, last_dig);
    got = finished;
    while (!got && lat < 2000) begin
      @(negedge clk);
      lat++;
      start = (v.poke_busy == lat);
      got = finished;
    end
    chk("finished_seen", got, 1'b1);
    if (v.exp_lat != 0) chk("latency", lat, v.exp_lat);
    chk("error_at_finish", error, v.exp_err);
    chk("busy_at_finish", busy, 1'b0);
    if (v.poke_fin) start = 1'b1;
    vb = valid_cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_no_access", valid_cyc - vb, 0);
    chk("finish_pulses", fin_cnt - fb, 1);
    chk("write_count", wr_cnt - wb, 8);
    chk("read_count", rd_cnt - rb, v.exp_rd);
    chk("run_count", run_cnt - runb, v.exp_runs);
    chk("hold_stable", hold_viol - hb, 0);
    chk("error_sticky", error, v.exp_err);
    chk("digest", digest, v.exp_dig);
    ivx = v.sel ? v.iv : std_iv;
    ok = 1'b1;
    for (int w = 0; w < 8; w++) begin
      if (wr_addr_log[(wb + w) % 512] != 3'(map_t[w])) ok = 1'b0;
      if (wr_data_log[(wb + w) % 512] != ivx[255-32*w -: 32]) ok = 1'b0;
    end
    chk("load_sequence", ok, 1'b1);
    last_dig = v.exp_dig;
  endtask

  initial begin
    int n, vb;
    // lat: 8 writes + nblk*(run + wait) + 8 reads + finish
    vecs[0] = mkv(0, 0, iv_a, 0, 3, 0,  0, 17, 0, mk_dig(std_iv, 0));
    vecs[1] = mkv(1, 1, iv_a, 0, 3, 0,  1, 21, 0, mk_dig(iv_a, 1));
    vecs[2] = mkv(3, 0, iv_a, 0, 5, 12, 0, 35, 0, mk_dig(std_iv, 3));
    vecs[3] = mkv(2, 1, iv_b, 1, 3, 0,  0, 0,  0, mk_dig(iv_b, 2));
    vecs[4] = mkv(1, 0, iv_b, 0, 1, 0,  0, 21, 0, mk_dig(std_iv, 1));
    vecs[5] = mkv(1, 1, iv_a, 0, 0, 0,  0, 27, 1, mk_dig(std_iv, 1));
    vecs[6] = mkv(0, 0, iv_b, 1, 3, 0,  0, 0,  0, mk_dig(std_iv, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {busy, finished, error, st_valid, st_run, st_addr, st_wstrb, st_wdata}, '0);
    chk("reset_digest", digest, '0);
    chk("st_delay", st_delay, DELAY_VAL);

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Reset while waiting on st_done.
    ready_mode = 0;
    done_lat   = 0;
    @(negedge clk);
    num_blocks = 16'd2; iv_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!st_run && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("run_reached", st_run, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {busy, finished, error, st_valid, st_run, st_addr, st_wstrb, st_wdata}, '0);
    chk("rst_mid_digest", digest, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vb = valid_cyc;
    repeat (6) @(negedge clk);
    chk("rst_no_access", valid_cyc - vb, 0);
    chk("rst_idle_busy", busy, 1'b0);
    last_dig = '0;

    run_op(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_sha_state_sequencer

`default_nettype wire
